// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver.
// Recovers frames of start bit, DATA_WIDTH data bits (LSB first), optional parity bit and
// one stop bit. Each bit is decided by a 2-of-3 majority vote around its centre.
//
// Ports:
//   clk          oversampling clock, Prescale x baud
//   RST          asynchronous active-low reset
//   RX_IN        serial line (idle high), already synchronised to clk
//   PAR_EN       1 = parity bit follows the data bits
//   PAR_TYP      0 = even parity, 1 = odd parity
//   Prescale     oversampling ratio (8, 16 or 32)
//   P_DATA       last correctly received data word
//   Data_Valid   one-cycle pulse when P_DATA updates
//   Parity_Error parity mismatch in the last frame
//   Stop_Error   stop bit sampled low in the last frame
module uart_rx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error
);

    localparam logic [3:0] LastBit = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [3:0]            bit_q, bit_d;
    logic                  samp_lo_q, samp_lo_d;
    logic                  samp_mid_q, samp_mid_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_fail_q, par_fail_d;
    logic                  stop_fail_q, stop_fail_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [5:0]            prescale_q, prescale_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [5:0] half, mid_lo, mid_hi, last_edge;
    logic       at_lo, at_mid, at_hi, at_last;
    logic       maj, glitch, start_ok, frame_start, frame_end, exp_par;

    assign half      = {1'b0, prescale_q[5:1]};
    assign mid_lo    = half - 6'd1;
    assign mid_hi    = half + 6'd1;
    assign last_edge = prescale_q - 6'd1;
    assign at_lo     = (edge_q == mid_lo);
    assign at_mid    = (edge_q == half);
    assign at_hi     = (edge_q == mid_hi);
    assign at_last   = (edge_q == last_edge);

    // Third sample is taken live from RX_IN in the evaluation cycle.
    assign maj = (samp_lo_q & samp_mid_q) | (samp_lo_q & RX_IN) | (samp_mid_q & RX_IN);

    assign glitch    = (state_q == StStart) && at_hi && maj;
    assign start_ok  = (state_q == StStart) && at_last;
    assign frame_end = (state_q == StStop) && at_last;
    // The cycle a low line is first seen counts as edge 0 of the start bit.
    assign frame_start = ((state_q == StIdle) && !RX_IN) || (frame_end && !RX_IN);
    assign exp_par     = (^shift_q) ^ par_typ_q;

    // State register
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            edge_q      <= '0;
            bit_q       <= '0;
            samp_lo_q   <= 1'b0;
            samp_mid_q  <= 1'b0;
            shift_q     <= '0;
            par_fail_q  <= 1'b0;
            stop_fail_q <= 1'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            prescale_q  <= '0;
            p_data_q    <= '0;
            dv_q        <= 1'b0;
            pe_q        <= 1'b0;
            se_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_q      <= edge_d;
            bit_q       <= bit_d;
            samp_lo_q   <= samp_lo_d;
            samp_mid_q  <= samp_mid_d;
            shift_q     <= shift_d;
            par_fail_q  <= par_fail_d;
            stop_fail_q <= stop_fail_d;
            par_en_q    <= par_en_d;
            par_typ_q   <= par_typ_d;
            prescale_q  <= prescale_d;
            p_data_q    <= p_data_d;
            dv_q        <= dv_d;
            pe_q        <= pe_d;
            se_q        <= se_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (!RX_IN) state_d = StStart;
            StStart: begin
                if (glitch)       state_d = StIdle;
                else if (at_last) state_d = StData;
            end
            StData:   if (at_last && (bit_q == LastBit)) state_d = par_en_q ? StParity : StStop;
            StParity: if (at_last) state_d = StStop;
            StStop:   if (at_last) state_d = RX_IN ? StIdle : StStart;
            default:  state_d = StIdle;
        endcase
    end

    // Counters, sampling, datapath and outputs
    always_comb begin
        edge_d      = edge_q;
        bit_d       = bit_q;
        samp_lo_d   = samp_lo_q;
        samp_mid_d  = samp_mid_q;
        shift_d     = shift_q;
        par_fail_d  = par_fail_q;
        stop_fail_d = stop_fail_q;
        par_en_d    = par_en_q;
        par_typ_d   = par_typ_q;
        prescale_d  = prescale_q;
        p_data_d    = p_data_q;
        dv_d        = 1'b0;
        pe_d        = pe_q;
        se_d        = se_q;

        if (frame_start) begin
            edge_d     = 6'd1;
            par_en_d   = PAR_EN;
            par_typ_d  = PAR_TYP;
            prescale_d = Prescale;
        end else if ((state_q == StIdle) || glitch || at_last) begin
            edge_d = '0;
        end else begin
            edge_d = edge_q + 6'd1;
        end

        if (state_q != StIdle) begin
            if (at_lo)  samp_lo_d  = RX_IN;
            if (at_mid) samp_mid_d = RX_IN;
        end

        if (start_ok) begin
            bit_d       = '0;
            par_fail_d  = 1'b0;
            stop_fail_d = 1'b0;
            pe_d        = 1'b0;
            se_d        = 1'b0;
        end

        if ((state_q == StData) && at_hi) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
                if (bit_q == i[3:0]) shift_d[i] = maj;
            end
        end
        if ((state_q == StData) && at_last && (bit_q != LastBit)) bit_d = bit_q + 4'd1;

        if ((state_q == StParity) && at_hi && (maj != exp_par)) par_fail_d = 1'b1;
        if ((state_q == StStop) && at_hi && !maj) stop_fail_d = 1'b1;

        if (frame_end) begin
            if (!par_fail_q && !stop_fail_q) begin
                p_data_d = shift_q;
                dv_d     = 1'b1;
                pe_d     = 1'b0;
                se_d     = 1'b0;
            end else begin
                pe_d = par_fail_q;
                se_d = stop_fail_q;
            end
        end
    end

    assign P_DATA       = p_data_q;
    assign Data_Valid   = dv_q;
    assign Parity_Error = pe_q;
    assign Stop_Error   = se_q;

endmodule
